// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer, transmitter and status signals of the uart tx fifo
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
  logic [7:0] s_data_i;
  logic s_valid_i;
  logic s_ready_o;
  logic flush_i;
  logic tx_start_o;
  logic [7:0] tx_data_o;
  logic tx_active_i;
  logic tx_done_i;
  logic [$clog2(DEPTH):0] level_o;
  logic empty_o;
  logic full_o;
  logic ack_err_o;
  modport slave (
    input s_data_i, s_valid_i, flush_i, tx_active_i, tx_done_i,
    output s_ready_o, tx_start_o, tx_data_o, level_o, empty_o, full_o, ack_err_o
  );
  modport master (
    output s_data_i, s_valid_i, flush_i, tx_active_i, tx_done_i,
    input s_ready_o, tx_start_o, tx_data_o, level_o, empty_o, full_o, ack_err_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte fifo that launches queued bytes back-to-back into a uart transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input logic clk,
  input logic resetn,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;
  state_t state_q;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [LW-1:0] level_q, level_d;
  logic [TW-1:0] timer_q;
  logic [7:0] data_q;
  logic start_q, err_q, push, pop;
  assign push = bus.s_valid_i && bus.s_ready_o;
  // a launch pops from IDLE when the transmitter is free, or straight from BUSY on its done pulse
  assign pop = level_q != '0 && (state_q == IDLE ? !bus.tx_active_i : state_q == BUSY && bus.tx_done_i);
  assign level_d = bus.flush_i ? '0 : level_q + LW'(push) - LW'(pop);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q <= '0;
      wr_q <= '0;
      level_q <= '0;
    end else begin
      rd_q <= bus.flush_i ? '0 : rd_q + AW'(pop);
      wr_q <= bus.flush_i ? '0 : wr_q + AW'(push);
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (push && !bus.flush_i) mem_q[wr_q] <= bus.s_data_i;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      data_q <= '0;
      timer_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.flush_i) err_q <= 1'b0;
      case (state_q)
        IDLE, BUSY: begin
          if (pop) begin
            data_q <= mem_q[rd_q];
            start_q <= 1'b1;
            timer_q <= '0;
            state_q <= LAUNCH;
          end else if (state_q == BUSY && bus.tx_done_i) begin
            state_q <= IDLE;
          end
        end
        LAUNCH: begin
          timer_q <= timer_q + TW'(1);
          if (bus.tx_active_i) begin
            start_q <= 1'b0;
            state_q <= BUSY;
          end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
            start_q <= 1'b0;
            err_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.s_ready_o = !bus.full_o;
  assign bus.full_o = level_q == LW'(DEPTH);
  assign bus.empty_o = level_q == '0;
  assign bus.level_o = level_q;
  assign bus.tx_start_o = start_q;
  assign bus.tx_data_o = data_q;
  assign bus.ack_err_o = err_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench against a byte-queue model, with a serial transmitter and line receiver
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int ACK = 15;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();
  uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q[$];
  logic [7:0] exp_tx[$];
  logic m_start = 1'b0;
  logic m_err = 1'b0;
  logic [7:0] m_data = '0;
  int m_ph = 0;
  int m_timer = 0;
  logic pushed = 1'b0;
  bit ack_en = 1'b1;
  bit tx_hold = 1'b0;
  bit in_frame = 1'b0;
  int tx_cnt = 0;
  int ack_wait = 0;
  int rx_cnt = 0;
  logic [7:0] tx_byte = '0;
  logic [7:0] rx_byte = '0;
  logic line = 1'b1;
  logic prev_start = 1'b0;
  int dut_starts = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // transmitter (acks start, serialises 8N1) and a mid-bit sampling receiver on its line
  task automatic env();
    logic [8:0] e;
    if (!resetn) begin
      bus.tx_active_i = 1'b0;
      bus.tx_done_i = 1'b0;
      in_frame = 1'b0;
      tx_cnt = 0;
      rx_cnt = 0;
      line = 1'b1;
      return;
    end
    if (bus.tx_done_i) begin
      bus.tx_done_i = 1'b0;
      in_frame = 1'b0;
    end else if (in_frame) begin
      tx_cnt++;
      bus.tx_done_i = tx_cnt == 10 * CPB - 1;
    end else if (bus.tx_start_o && ack_en && !tx_hold) begin
      if (ack_wait == 0) begin
        in_frame = 1'b1;
        tx_cnt = 0;
        tx_byte = bus.tx_data_o;
        ack_wait = $urandom_range(0, 3);
      end else ack_wait--;
    end
    bus.tx_active_i = in_frame || tx_hold;
    line = (!in_frame || tx_cnt / CPB == 9) ? 1'b1 : (tx_cnt / CPB == 0) ? 1'b0 : tx_byte[tx_cnt / CPB - 1];
    if (rx_cnt == 0) begin
      if (!line) rx_cnt = 1;
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2 && rx_cnt > CPB && rx_cnt < 9 * CPB) rx_byte = {line, rx_byte[7:1]};
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        e = 9'h100;
        if (exp_tx.size() > 0) e = {1'b0, exp_tx.pop_front()};
        check("rx_byte", {1'b0, rx_byte}, e);
        rx_cnt = 0;
      end
    end
  endtask
  task automatic step();
    bit launch;
    int lvl;
    @(posedge clk);
    pushed = 1'b0;
    lvl = q.size();
    if (!resetn) begin
      q.delete();
      exp_tx.delete();
      m_start = 1'b0;
      m_err = 1'b0;
      m_ph = 0;
      m_timer = 0;
    end else begin
      launch = lvl > 0 && (m_ph == 0 ? !bus.tx_active_i : (m_ph == 2 && bus.tx_done_i));
      if (bus.flush_i) m_err = 1'b0;
      if (launch) begin
        m_data = q.pop_front();
        m_start = 1'b1;
        m_timer = 0;
        m_ph = 1;
      end else if (m_ph == 1) begin
        if (bus.tx_active_i) begin
          m_start = 1'b0;
          m_ph = 2;
          exp_tx.push_back(m_data);
        end else if (m_timer == ACK - 1) begin
          m_start = 1'b0;
          m_err = 1'b1;
          m_ph = 0;
        end
        m_timer++;
      end else if (m_ph == 2 && bus.tx_done_i) m_ph = 0;
      pushed = bus.s_valid_i && lvl < DEPTH;
      if (bus.flush_i) q.delete();
      else if (pushed) q.push_back(bus.s_data_i);
    end
    #1;
    check("level", 32'(bus.level_o), q.size());
    check("flags", {bus.tx_start_o, bus.ack_err_o, bus.full_o, bus.empty_o, bus.s_ready_o},
          {m_start, m_err, q.size() == DEPTH, q.size() == 0, q.size() != DEPTH});
    if (m_start) check("tx_data", bus.tx_data_o, m_data);
    if (bus.tx_start_o && !prev_start) dut_starts++;
    prev_start = bus.tx_start_o;
    env();
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic push_byte(input logic [7:0] b);
    bus.s_valid_i = 1'b1;
    bus.s_data_i = b;
    pushed = 1'b0;
    for (int k = 0; k < 400 && !pushed; k++) step();
    if (!pushed) check("push_timeout", pushed, 1);
    bus.s_valid_i = 1'b0;
  endtask
  task automatic wait_frame();
    for (int k = 0; k < 60 && !in_frame; k++) step();
    if (!in_frame) check("frame_timeout", in_frame, 1);
  endtask
  initial begin
    int s0;
    bit done;
    bus.s_valid_i = 1'b0;
    bus.s_data_i = '0;
    bus.flush_i = 1'b0;
    bus.tx_active_i = 1'b0;
    bus.tx_done_i = 1'b0;
    idle(3);
    check("rst_level", 32'(bus.level_o), 0);
    check("rst_flags", {bus.tx_start_o, bus.ack_err_o, bus.full_o, bus.empty_o, bus.s_ready_o}, 5'b00011);
    resetn = 1'b1;
    push_byte(8'hA5);
    step();
    check("a5_start", bus.tx_start_o, 1);
    idle(200);
    tx_hold = 1'b1;
    step();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("burst_full", bus.full_o, 1);
    check("burst_ready", bus.s_ready_o, 0);
    tx_hold = 1'b0;
    bus.tx_active_i = 1'b0;
    push_byte(8'h10);
    idle(17 * 10 * CPB + 200);
    push_byte(8'h77);
    wait_frame();
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("flush_level", 32'(bus.level_o), 0);
    s0 = dut_starts;
    idle(250);
    check("flush_nostart", dut_starts - s0, 0);
    ack_en = 1'b0;
    push_byte(8'h3C);
    idle(20);
    check("ack_err", bus.ack_err_o, 1);
    check("ack_start_low", bus.tx_start_o, 0);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("ack_err_clr", bus.ack_err_o, 0);
    ack_en = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(8'h50 + 8'(i));
    wait_frame();
    idle(20);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    check("rstmid_level", 32'(bus.level_o), 0);
    for (int c = 0; c < 4000; c++) begin
      bus.s_valid_i = $urandom_range(0, c < 2000 ? 60 : 3) == 0;
      bus.s_data_i = 8'($urandom);
      bus.flush_i = $urandom_range(0, 299) == 0;
      step();
    end
    bus.s_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      step();
      done = q.size() == 0 && m_ph == 0 && !in_frame && rx_cnt == 0;
    end
    check("drain_done", done, 1);
    check("drain_left", exp_tx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
